// File: rtl/camo_key_loader.sv
// Serial key loader for obfuscated-gate select bus D: LSB-first frame capture, atomic commit, lock until reset.
// Optional even-parity beat enabled by defining CAMO_KEY_PARITY_EN.
module camo_key_loader #(
    parameter int NUM_SITES = 5,
    parameter int KEY_W     = 2 * NUM_SITES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic             key_bit,
    input  logic             key_last,
    output logic             key_ready,
    output logic [KEY_W-1:0] D,
    output logic             key_locked,
    output logic             err
);

`ifdef CAMO_KEY_PARITY_EN
    localparam int FRAME_LEN = KEY_W + 1;
`else
    localparam int FRAME_LEN = KEY_W;
`endif
    localparam int CNT_W = $clog2(KEY_W + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [FRAME_LEN-1:0] shadow;
    logic                 beat;
    logic                 parity_ok;

    assign beat = key_valid && key_ready;

`ifdef CAMO_KEY_PARITY_EN
    // Key bits plus parity bit must XOR to zero (even parity).
    assign parity_ok = ~(^shadow);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= LOAD;
            cnt        <= '0;
            shadow     <= '0;
            D          <= '0;
            key_locked <= 1'b0;
            err        <= 1'b0;
            key_ready  <= 1'b1;
        end else begin
            case (state)
                LOAD: begin
                    if (beat) begin
                        for (int i = 0; i < FRAME_LEN; i++) begin
                            if (cnt == CNT_W'(i)) shadow[i] <= key_bit;
                        end
                        cnt <= cnt + 1'b1;
                        if (key_last && cnt == LAST_CNT) begin
                            state     <= CHECK;
                            key_ready <= 1'b0;
                        end else if (key_last || cnt == LAST_CNT) begin
                            // Early or missing last marker: frame is rejected.
                            state     <= ERR;
                            key_ready <= 1'b0;
                            err       <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (parity_ok) begin
                        D          <= shadow[KEY_W-1:0];
                        key_locked <= 1'b1;
                        state      <= LOCKED;
                    end else begin
                        state <= ERR;
                        err   <= 1'b1;
                    end
                end
                LOCKED: begin
                    state <= LOCKED;
                end
                ERR: begin
                    err       <= 1'b0;
                    shadow    <= '0;
                    cnt       <= '0;
                    key_ready <= 1'b1;
                    state     <= LOAD;
                end
                default: begin
                    state     <= LOAD;
                    key_ready <= 1'b1;
                    err       <= 1'b0;
                end
            endcase
        end
    end

endmodule
